ahb_master: RTL

AHB_MASTER -- requirements
Module: ahb_master

---
 rtl/ahb_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_master.sv
// -----------------------------------------------------------------------------
// ahb_master
//
// Purpose:
//    Single-transfer AHB-Lite master. Accepts one command at a time on a
//    valid/ready handshake and performs one non-pipelined 64-bit SINGLE
//    transfer: an address phase, then a data phase. It then returns a one-cycle
//    response pulse carrying read data and an error indication.
//
// Parameters:
//    WAIT_LIMIT  maximum consecutive data-phase cycles with HREADY low before
//                the transfer is abandoned and reported as an error.
//
// Ports:
//    HCLK, HRESET       clock (rising edge) and synchronous active-high reset
//    cmd_valid/ready    command handshake; ready only while idle
//    cmd_write          1 = write, 0 = read
//    cmd_addr           byte address
//    cmd_wdata          write data
//    rsp_valid          one-cycle completion pulse
//    rsp_rdata          read data (held across writes and errors)
//    rsp_error          slave ERROR response or wait timeout
//    HADDR .. HWDATA    AHB master outputs
//    HREADY, HRESP      AHB slave handshake and response
//    HRDATA             AHB read data
// -----------------------------------------------------------------------------
module ahb_master #(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   // command side
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [63:0] cmd_wdata,
   // response side
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        rsp_error,
   // AHB master interface
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [63:0] HWDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [63:0] HRDATA
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
   // Last count value before the limit: a low-HREADY cycle seen at this
   // count is the WAIT_LIMIT-th one, so the transfer is abandoned there.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   logic [1:0]       state_q,     state_d;
   logic [31:0]      haddr_q,     haddr_d;
   logic             hwrite_q,    hwrite_d;
   logic [63:0]      wdata_q,     wdata_d;
   logic [63:0]      hwdata_q,    hwdata_d;
   logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
   logic             err_q,       err_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [63:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_error_q, rsp_error_d;

   // Next-state and datapath logic
   always_comb begin
      state_d     = state_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      wdata_d     = wdata_q;
      hwdata_d    = hwdata_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               // Capture the whole command so the requester may change its
               // inputs immediately after the handshake.
               haddr_d  = cmd_addr;
               hwrite_d = cmd_write;
               wdata_d  = cmd_wdata;
               state_d  = ST_ADDR;
            end
         end

         ST_ADDR: begin
            // The address phase is only taken by the slave when HREADY is high.
            if (HREADY) begin
               state_d    = ST_DATA;
               hwdata_d   = wdata_q;
               wait_cnt_d = '0;
               err_d      = 1'b0;
            end
         end

         ST_DATA: begin
            if (HREADY) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_error_d = HRESP | err_q;
               // Read data is only meaningful for a successful read.
               if (!hwrite_q && !HRESP && !err_q) begin
                  rsp_rdata_d = HRDATA;
               end
               err_d      = 1'b0;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_LAST) begin
               // Slave stalled too long: give up, report error, keep old data.
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               err_d       = 1'b0;
               wait_cnt_d  = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
               // First cycle of a two-cycle ERROR response; remember it so
               // the completion reports the error.
               if (HRESP) begin
                  err_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         wdata_q     <= '0;
         hwdata_q    <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         wdata_q     <= wdata_d;
         hwdata_q    <= hwdata_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   // Outputs. NONSEQ is driven only during the address phase; the data phase
   // (including the first cycle of an ERROR response) always shows IDLE.
   assign cmd_ready = (state_q == ST_IDLE);
   assign HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = 3'b011;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule
